// File: rtl/vdp18_scandbl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vdp18_scandbl_if
//  Description : Signal bundle between the VDP timing/colour pipeline and the
//                line-doubling scan converter.
//                master : the source side (VDP timing + colour pipeline)
//                slave  : the scan doubler
//  Signals     : clk_en_5m37_i  source pixel enable
//                clk_en_10m7_i  output pixel enable
//                num_pix_i      signed source pixel counter
//                vert_inc_i     source line advance (qualified by 5m37 enable)
//                vsync_n_i      source vsync (active low)
//                vblank_i       source vblank
//                col_i          colour index of pixel num_pix_i
//                scanline_i     scanline darkening (VDP18_SCANLINES_EN only)
//                col_o          doubled colour index
//                hsync_n_o      output hsync (active low)
//                vsync_n_o      output vsync (active low)
//                hblank_o       output hblank
//                vblank_o       output vblank
//                pass_o         0 = first replay, 1 = second replay
//  Options     : VDP18_SCANLINES_EN adds scanline_i
//  Revision    : 1.0  initial release
// ============================================================================
interface vdp18_scandbl_if;
    logic              clk_en_5m37_i;
    logic              clk_en_10m7_i;
    logic signed [8:0] num_pix_i;
    logic              vert_inc_i;
    logic              vsync_n_i;
    logic              vblank_i;
    logic [3:0]        col_i;
`ifdef VDP18_SCANLINES_EN
    logic              scanline_i;
`endif
    logic [3:0]        col_o;
    logic              hsync_n_o;
    logic              vsync_n_o;
    logic              hblank_o;
    logic              vblank_o;
    logic              pass_o;

    modport master (
        output clk_en_5m37_i, clk_en_10m7_i, num_pix_i, vert_inc_i,
               vsync_n_i, vblank_i, col_i,
`ifdef VDP18_SCANLINES_EN
               scanline_i,
`endif
        input  col_o, hsync_n_o, vsync_n_o, hblank_o, vblank_o, pass_o
    );

    modport slave (
        input  clk_en_5m37_i, clk_en_10m7_i, num_pix_i, vert_inc_i,
               vsync_n_i, vblank_i, col_i,
`ifdef VDP18_SCANLINES_EN
               scanline_i,
`endif
        output col_o, hsync_n_o, vsync_n_o, hblank_o, vblank_o, pass_o
    );
endinterface
`default_nettype wire

// File: rtl/vdp18_scandbl.sv
`default_nettype none
// ============================================================================
//  Module      : vdp18_scandbl
//  Description : Line-doubling scan converter. Each source line (5.37 MHz
//                pixels) is captured into one bank of a ping-pong line buffer
//                while the previous line is replayed twice from the other
//                bank at 10.74 MHz, giving 31 kHz output. hsync/hblank are
//                regenerated from the read-side pixel counter; vsync/vblank
//                are re-timed to output line starts.
//  Ports       : clk_i    system clock
//                reset_i  asynchronous active-high reset
//                vdp      vdp18_scandbl_if.slave bundle (enables, pixel
//                         counter, line advance, sync/blank, colours)
//  Options     : VDP18_SCANLINES_EN - adds scanline_i; the second replay of
//                each line is forced to colour 1 (black) while it is high.
//  Revision    : 1.0  initial release
// ============================================================================
module vdp18_scandbl #(
    parameter int HS_START_G = -64,
    parameter int HS_LEN_G   = 26,
    parameter int BL_START_G = -72,
    parameter int BL_END_G   = -14
) (
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    vdp18_scandbl_if.slave     vdp
);

    localparam logic signed [8:0] HS_ON     = 9'(HS_START_G);
    localparam logic signed [8:0] HS_OFF    = 9'(HS_START_G + HS_LEN_G);
    localparam logic signed [8:0] BL_ON     = 9'(BL_START_G);
    localparam logic signed [8:0] BL_OFF    = 9'(BL_END_G);
    localparam logic signed [8:0] PIX_FIRST = -9'sd86;
    localparam logic signed [8:0] PIX_LAST  = 9'sd255;

    // Line buffer banks (contents deliberately not reset)
    logic [3:0] mem0 [0:511];
    logic [3:0] mem1 [0:511];

    logic              wr_sel_q;
    logic signed [8:0] prev_pix_q;
    logic signed [8:0] first_q;
    logic signed [8:0] last_q;
    logic signed [8:0] rd_pix_q;
    logic              pass_q;
    logic [3:0]        col_q;
    logic              hsync_n_q;
    logic              hblank_q;
    logic              vsync_n_q;
    logic              vblank_q;

    logic              line_start;
    logic [8:0]        wr_addr;
    logic [8:0]        rd_addr;
    logic [3:0]        col_mux;

    // vert_inc is only meaningful on a source pixel enable
    assign line_start = vdp.vert_inc_i & vdp.clk_en_5m37_i;

    // Flipping the sign bit maps -256..255 onto 0..511
    assign wr_addr = {~vdp.num_pix_i[8], vdp.num_pix_i[7:0]};
    assign rd_addr = {~rd_pix_q[8], rd_pix_q[7:0]};

    always_ff @(posedge clk_i) begin
        if (vdp.clk_en_5m37_i) begin
            if (wr_sel_q) begin
                mem1[wr_addr] <= vdp.col_i;
            end else begin
                mem0[wr_addr] <= vdp.col_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_sel_q   <= 1'b0;
            prev_pix_q <= PIX_FIRST;
            first_q    <= PIX_FIRST;
            last_q     <= PIX_LAST;
            rd_pix_q   <= PIX_FIRST;
            pass_q     <= 1'b0;
            col_q      <= 4'd0;
            hsync_n_q  <= 1'b1;
            hblank_q   <= 1'b0;
            vsync_n_q  <= 1'b1;
            vblank_q   <= 1'b0;
        end else begin
            // Source side: line-length tracking and bank swap
            if (vdp.clk_en_5m37_i) begin
                prev_pix_q <= vdp.num_pix_i;
                // A backwards step of the pixel counter marks the start of a
                // new source line, so it gives both ends of the line.
                if (vdp.num_pix_i < prev_pix_q) begin
                    first_q <= vdp.num_pix_i;
                    last_q  <= prev_pix_q;
                end
                if (vdp.vert_inc_i) begin
                    wr_sel_q  <= ~wr_sel_q;
                    vsync_n_q <= vdp.vsync_n_i;
                    vblank_q  <= vdp.vblank_i;
                end
            end

            // Read side: restart wins over a coincident wrap
            if (line_start) begin
                rd_pix_q <= first_q;
                pass_q   <= 1'b0;
            end else if (vdp.clk_en_10m7_i) begin
                if (rd_pix_q == last_q) begin
                    rd_pix_q <= first_q;
                    pass_q   <= ~pass_q;
                end else begin
                    rd_pix_q <= rd_pix_q + 9'sd1;
                end
            end

            if (vdp.clk_en_10m7_i) begin
                if (rd_pix_q == HS_ON) begin
                    hsync_n_q <= 1'b0;
                end else if (rd_pix_q == HS_OFF) begin
                    hsync_n_q <= 1'b1;
                end
                if (rd_pix_q == BL_ON) begin
                    hblank_q <= 1'b1;
                end else if (rd_pix_q == BL_OFF) begin
                    hblank_q <= 1'b0;
                end
            end

            // Read bank is always the one not being written
            col_q <= wr_sel_q ? mem0[rd_addr] : mem1[rd_addr];
        end
    end

    always_comb begin
        col_mux = col_q;
`ifdef VDP18_SCANLINES_EN
        if (vdp.scanline_i && pass_q) begin
            col_mux = 4'd1;
        end
`endif
        if (hblank_q) begin
            col_mux = 4'd0;
        end
    end

    assign vdp.col_o     = col_mux;
    assign vdp.hsync_n_o = hsync_n_q;
    assign vdp.vsync_n_o = vsync_n_q;
    assign vdp.hblank_o  = hblank_q;
    assign vdp.vblank_o  = vblank_q;
    assign vdp.pass_o    = pass_q;

endmodule
`default_nettype wire
